product_accumulator: RTL and testbench

Sequential accumulation stage that sits directly downstream of the combinational 8-bit multiplier in the PE datapath. It accepts one 17-bit product per handshake, sums exactly `LEN` products into an `ACC_W`-bit accumulator, then presents the dot-product result on a valid/ready output port. It tracks overflow, supports a synchronous abort, and holds each result until the consumer takes it.

---
 rtl/product_accumulator.sv | 147 ++++++++++++++
 tb/tb_product_accumulator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Accumulation stage behind the 8-bit multiplier in the PE datapath. It
// takes one unsigned PROD_W-bit product per in_valid/in_ready handshake, sums
// exactly LEN of them into an ACC_W-bit accumulator, and then holds the
// dot-product result on a valid/ready output until the consumer takes it.
//
// Parameters:
//   PROD_W  product width (>= 1)
//   ACC_W   accumulator / result width (>= PROD_W)
//   LEN     products per result (>= 1)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (same effect as clear)
//   clear         synchronous abort, drops any partial or held result
//   in_valid      in_product is valid
//   in_ready      block can accept a product (ACCUM state, not in reset)
//   in_product    unsigned product
//   out_valid     out_sum / out_overflow hold a finished result
//   out_ready     consumer accepts the result
//   out_sum       accumulator value (partial sum while accumulating)
//   out_overflow  a carry left bit ACC_W-1 during this result
//
// Build option:
//   PRODUCT_ACC_SATURATE_EN  defined   -> accumulator clamps to all ones on
//                                         carry-out and stays clamped
//                            undefined -> accumulator wraps modulo 2^ACC_W
//   out_overflow is reported the same way in both builds.
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 17,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    // Elaboration-time guards on the parameter ranges.
    generate
        if (ACC_W < PROD_W) begin : g_bad_acc_w
            $error("product_accumulator: ACC_W must be >= PROD_W");
        end
        if (LEN < 1) begin : g_bad_len
            $error("product_accumulator: LEN must be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic               w_accept;
    logic [ACC_W:0]     w_sum_ext;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    assign w_accept  = in_valid && in_ready;
    // One spare bit on top of the accumulator captures the carry-out.
    assign w_sum_ext = {1'b0, r_acc} + (ACC_W + 1)'(in_product);
    assign w_carry   = w_sum_ext[ACC_W];
    assign w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next accumulator value: wrap or clamp depending on the build.
    always_comb begin
        w_acc_nxt = w_sum_ext[ACC_W-1:0];
`ifdef PRODUCT_ACC_SATURATE_EN
        // Once a result has overflowed it stays pinned at all ones.
        if (w_carry || r_ovf) begin
            w_acc_nxt = {ACC_W{1'b1}};
        end else begin
            w_acc_nxt = w_sum_ext[ACC_W-1:0];
        end
`endif
    end

    // Control FSM plus accumulator, beat counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            // Abort wins over both handshakes; an offered beat is discarded.
            r_state <= ST_ACCUM;
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= r_ovf | w_carry;
                        if (w_cnt_nxt == LEN_C) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end else begin
                        r_state <= ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_ACCUM;
                        r_acc   <= {ACC_W{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                        r_ovf   <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                    r_acc   <= {ACC_W{1'b0}};
                    r_cnt   <= {CNT_W{1'b0}};
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

    // in_ready also drops combinationally with rst so nothing is taken in reset.
    assign in_ready     = (r_state == ST_ACCUM) && !rst;
    assign out_valid    = (r_state == ST_DONE);
    assign out_sum      = r_acc;
    assign out_overflow = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        out_ready;
    logic [16:0] prod;
    logic        v4, v8, vov;

    // DUT A: LEN=4, ACC_W=24
    logic        a_in_ready, a_out_valid, a_ovf;
    logic [23:0] a_sum;
    // DUT B: LEN=8, ACC_W=24
    logic        b_in_ready, b_out_valid, b_ovf;
    logic [23:0] b_sum;
    // DUT C: LEN=4, ACC_W=18
    logic        c_in_ready, c_out_valid, c_ovf;
    logic [17:0] c_sum;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [23:0] sum;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    product_accumulator #(.PROD_W(17), .ACC_W(24), .LEN(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v4), .in_ready(a_in_ready),
        .in_product(prod), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_sum), .out_overflow(a_ovf));

    product_accumulator #(.PROD_W(17), .ACC_W(24), .LEN(8)) dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(v8), .in_ready(b_in_ready),
        .in_product(prod), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_sum), .out_overflow(b_ovf));

    product_accumulator #(.PROD_W(17), .ACC_W(18), .LEN(4)) dut_c (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(vov), .in_ready(c_in_ready),
        .in_product(prod), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_sum(c_sum), .out_overflow(c_ovf));

    always #5 clk = ~clk;

    // Cycle index, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat to the selected DUT (0=A,1=B,2=C) and let it be accepted.
    task automatic beat(input int which, input logic [16:0] p);
        prod = p;
        v4   = (which == 0);
        v8   = (which == 1);
        vov  = (which == 2);
        step();
        v4   = 1'b0;
        v8   = 1'b0;
        vov  = 1'b0;
    endtask

    task automatic push(input int which, input logic [23:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.cyc = cyc;
        if (which == 0) qa.push_back(e);
        else if (which == 1) qb.push_back(e);
        else qc.push_back(e);
    endtask

    // Monitors: each new result is popped and checked for value and latency.
    logic pa = 1'b0, pb = 1'b0, pc = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (a_out_valid && !pa) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL monA_unexpected actual=0x%0h required=none", a_sum);
            end else begin
                e = qa.pop_front();
                chk("monA_sum", {8'd0, a_sum}, {8'd0, e.sum});
                chk("monA_ovf", {31'd0, a_ovf}, {31'd0, e.ovf});
                chk("monA_latency", cyc, e.cyc);
            end
        end
        if (b_out_valid && !pb) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL monB_unexpected actual=0x%0h required=none", b_sum);
            end else begin
                e = qb.pop_front();
                chk("monB_sum", {8'd0, b_sum}, {8'd0, e.sum});
                chk("monB_ovf", {31'd0, b_ovf}, {31'd0, e.ovf});
                chk("monB_latency", cyc, e.cyc);
            end
        end
        if (c_out_valid && !pc) begin
            if (qc.size() == 0) begin
                checks++; failures++;
                $display("FAIL monC_unexpected actual=0x%0h required=none", c_sum);
            end else begin
                e = qc.pop_front();
                chk("monC_sum", {14'd0, c_sum}, {8'd0, e.sum});
                chk("monC_ovf", {31'd0, c_ovf}, {31'd0, e.ovf});
                chk("monC_latency", cyc, e.cyc);
            end
        end
        pa = a_out_valid;
        pb = b_out_valid;
        pc = c_out_valid;
    end

    logic [16:0] basic_vec [4];
    int          accepts;

    initial begin
        basic_vec[0] = 17'h00D26;
        basic_vec[1] = 17'h02E26;
        basic_vec[2] = 17'h087A6;
        basic_vec[3] = 17'h00001;
        rst = 1'b1; clear = 1'b0; out_ready = 1'b1; prod = 17'd0;
        v4 = 1'b0; v8 = 1'b0; vov = 1'b0;
        step(); step();
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_out_sum", {8'd0, a_sum}, 32'd0);
        chk("rst_out_ovf", {31'd0, a_ovf}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, a_in_ready}, 32'd1);

        // Basic dot product.
        for (int i = 0; i < 4; i++) beat(0, basic_vec[i]);
        push(0, 24'h00C2F3, 1'b0);
        step();
        chk("basic_valid_one_cycle", {31'd0, a_out_valid}, 32'd0);
        chk("basic_in_ready_back", {31'd0, a_in_ready}, 32'd1);

        // Back-pressure.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(0, basic_vec[i]);
        push(0, 24'h00C2F3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_sum", {8'd0, a_sum}, 32'h0000C2F3);
            chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
            chk("bp_valid", {31'd0, a_out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_released", {31'd0, a_out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) beat(0, 17'h00001);
        push(0, 24'h000004, 1'b0);
        step();

        // Overflow on the 18-bit instance.
        for (int i = 0; i < 4; i++) beat(2, 17'h1FFFF);
`ifdef PRODUCT_ACC_SATURATE_EN
        push(2, 24'h03FFFF, 1'b1);
`else
        push(2, 24'h03FFFC, 1'b1);
`endif
        step();

        // Gapped input on the LEN=8 instance.
        accepts = 0;
        for (int i = 0; i < 16; i++) begin
            if ((i % 2) == 0) begin
                beat(1, 17'h00010);
                accepts++;
                if (accepts == 8) push(1, 24'h000080, 1'b0);
            end else begin
                step();
            end
        end

        // Abort with cnt=2 while a beat is offered.
        beat(0, 17'h00005);
        beat(0, 17'h00005);
        clear = 1'b1;
        beat(0, 17'h00100);
        clear = 1'b0;
        chk("abort_sum_zero", {8'd0, a_sum}, 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(0, 17'h00002);
        push(0, 24'h000008, 1'b0);
        step();
        chk("abort_done_held", {31'd0, a_out_valid}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_in_done_valid", {31'd0, a_out_valid}, 32'd0);
        chk("clear_in_done_sum", {8'd0, a_sum}, 32'd0);
        chk("clear_in_done_ready", {31'd0, a_in_ready}, 32'd1);
        out_ready = 1'b1;

        // Reset in the middle of a run.
        for (int i = 0; i < 3; i++) beat(0, 17'h00003);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready_now", {31'd0, a_in_ready}, 32'd0);
        step();
        chk("midrst_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("midrst_sum", {8'd0, a_sum}, 32'd0);
        chk("midrst_valid", {31'd0, a_out_valid}, 32'd0);
        chk("midrst_ovf", {31'd0, a_ovf}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", {31'd0, a_in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) beat(0, 17'h00003);
        push(0, 24'h00000C, 1'b0);
        step();
        step();

        chk("queue_a_drained", qa.size(), 32'd0);
        chk("queue_b_drained", qb.size(), 32'd0);
        chk("queue_c_drained", qc.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
